// File: rtl/keypad_pkg.sv
// Shared types and defaults for the keypad matrix scanner and its key-code queue.
// Holds the scan FSM state encoding and the key-code width helper.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE,
    ST_GHOST
  } scan_state_e;

  localparam int DEF_ROWS            = 4;
  localparam int DEF_COLS            = 4;
  localparam int DEF_SETTLE_CYCLES   = 3;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_FIFO_DEPTH      = 4;

  // Wide enough for SETTLE_CYCLES and DEBOUNCE_CYCLES up to 2^16-1.
  localparam int CNT_W = 16;

  function automatic int code_width(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction

endpackage

// File: rtl/keypad_key_fifo.sv
// Synchronous key-code queue: push/pop in one cycle, head visible combinationally (0 when empty).
// A push into a full queue is dropped and flagged on drop_o unless a pop frees the slot that cycle.
module keypad_key_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o,
  output logic         drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // A pop on a full queue frees the slot the simultaneous push writes into.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && !do_push;

  assign head_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + PW'(1);
    if (do_pop)  rd_d = rd_q + PW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Scans a ROWS x COLS key matrix, debounces press and release, rejects ghost patterns.
// A code enters the queue on the edge leaving DEBOUNCE; consumer pops with key_valid & key_ready.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int  ROWS            = DEF_ROWS,
  parameter int  COLS            = DEF_COLS,
  parameter int  SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
  parameter int  DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int  FIFO_DEPTH      = DEF_FIFO_DEPTH,
  localparam int CW              = code_width(ROWS, COLS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [ROWS-1:0] row_in,
  output logic [COLS-1:0] col_drive,
  output logic [CW-1:0]   key_code,
  output logic            key_valid,
  input  logic            key_ready,
  output logic            key_held,
  output logic            overflow,
  input  logic            overflow_clr
);

  localparam int RW = $clog2(ROWS);
  localparam int XW = $clog2(COLS);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [ROWS-1:0]  row_s1_q;
  logic [ROWS-1:0]  rs_q;
  scan_state_e      state_q, state_d;
  logic [XW-1:0]    col_idx_q, col_idx_d;
  logic [RW-1:0]    row_idx_q, row_idx_d;
  logic [ROWS-1:0]  pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overflow_q, overflow_d;

  logic             rs_zero;
  logic             rs_onehot;
  logic [RW-1:0]    rs_idx;
  logic [COLS-1:0]  col_onehot;
  logic             push;
  logic [CW-1:0]    push_code;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_drop;

  assign rs_zero    = (rs_q == '0);
  assign rs_onehot  = !rs_zero && ((rs_q & (rs_q - ROWS'(1))) == '0);
  assign col_onehot = COLS'(1) << col_idx_q;
  assign push_code  = CW'(row_idx_q) * CW'(COLS) + CW'(col_idx_q);

  always_comb begin
    rs_idx = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (rs_q[r]) rs_idx = RW'(r);
    end
  end

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    pat_d     = pat_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    key_held  = 1'b0;
    col_drive = '1;

    unique case (state_q)
      ST_IDLE: begin
        if (!rs_zero) begin
          state_d   = ST_SETTLE;
          col_idx_d = '0;
          cnt_d     = '0;
        end
      end

      ST_SETTLE: begin
        col_drive = col_onehot;
        if (cnt_q >= SETTLE_LAST) begin
          state_d = ST_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SAMPLE: begin
        col_drive = col_onehot;
        if (rs_zero) begin
          cnt_d = '0;
          if (col_idx_q == XW'(COLS - 1)) begin
            state_d   = ST_IDLE;
            col_idx_d = '0;
          end else begin
            state_d   = ST_SETTLE;
            col_idx_d = col_idx_q + XW'(1);
          end
        end else if (rs_onehot) begin
          state_d   = ST_DEBOUNCE;
          row_idx_d = rs_idx;
          pat_d     = rs_q;
          cnt_d     = CNT_W'(1);
        end else begin
          state_d = ST_GHOST;
          cnt_d   = '0;
        end
      end

      // The sample cycle already counted as the first stable observation.
      ST_DEBOUNCE: begin
        col_drive = col_onehot;
        if (rs_q == pat_q) begin
          if (cnt_q >= DEB_LAST) begin
            push    = 1'b1;
            state_d = ST_PRESSED;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PRESSED: begin
        col_drive = col_onehot;
        key_held  = 1'b1;
        if (rs_zero) begin
          state_d = (DEBOUNCE_CYCLES == 1) ? ST_IDLE : ST_RELEASE;
          cnt_d   = CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        col_drive = col_onehot;
        key_held  = 1'b1;
        if (!rs_zero) begin
          state_d = ST_PRESSED;
        end else if (cnt_q >= DEB_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_GHOST: begin
        if (!rs_zero) begin
          cnt_d = '0;
        end else if (cnt_q >= DEB_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // A set in the same cycle as a clear wins so no drop goes unreported.
  always_comb begin
    overflow_d = overflow_q;
    if (overflow_clr) overflow_d = 1'b0;
    if (fifo_drop)    overflow_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_s1_q   <= '0;
      rs_q       <= '0;
      state_q    <= ST_IDLE;
      col_idx_q  <= '0;
      row_idx_q  <= '0;
      pat_q      <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      row_s1_q   <= row_in;
      rs_q       <= row_s1_q;
      state_q    <= state_d;
      col_idx_q  <= col_idx_d;
      row_idx_q  <= row_idx_d;
      pat_q      <= pat_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  keypad_key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (CW)
  ) u_key_fifo (
    .clk_i      (clock),
    .rst_ni     (reset),
    .push_i     (push),
    .push_dat_i (push_code),
    .pop_i      (key_ready),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (key_code),
    .drop_o     (fifo_drop)
  );

  assign key_valid = !fifo_empty;
  assign overflow  = overflow_q;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
Parametrised successor to the 4x4 hex keypad scanner. Scans a ROWS x COLS key matrix and synchronises the raw row inputs. Debounces both press and release and rejects multi-key (ghost) patterns. Each accepted key code is queued in a small FIFO and handed to the consumer over a valid/ready handshake. Sits between the keypad pins and the system controller.

Parameters:
ROWS, 4, number of matrix rows (2..8)
COLS, 4, number of matrix columns (2..8)
SETTLE_CYCLES, 3, cycles to hold a column drive before sampling rows (min 3, to cover the 2-flop sync)
DEBOUNCE_CYCLES, 4, consecutive stable samples required for press and for release (1..2^16-1)
FIFO_DEPTH, 4, key code queue depth (power of 2, min 2)
CW, $clog2(ROWS*COLS), key code width (derived, not overridable)

Ports:
clock  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-low reset
row_in  in  ROWS  raw row lines from keypad, asynchronous to clock, 1 = contact
col_drive  out  COLS  column drive, 1 = driven
key_code  out  CW  FIFO head code = row_index*COLS + col_index
key_valid  out  1  FIFO non-empty
key_ready  in  1  consumer accepts head when key_valid & key_ready
key_held  out  1  1 while an accepted key is still pressed
overflow  out  1  sticky: an accepted code was dropped because the FIFO was full
overflow_clr  in  1  synchronous clear of overflow

Behaviour:
- Reset (reset=0, async): FSM=IDLE, counters 0, FIFO empty, sync flops 0. Outputs: col_drive all-ones, key_code 0, key_valid 0, key_held 0, overflow 0.
- Synchroniser: 2 flops on row_in; all decisions use the synchronised value rs.
- FSM states: IDLE, SETTLE, SAMPLE, DEBOUNCE, PRESSED, RELEASE, GHOST.
- IDLE: col_drive all-ones; when rs != 0 go to SETTLE with col_idx=0.
- SETTLE: col_drive = one-hot(col_idx); wait SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE (1 cycle):
  - rs == 0: col_idx++, then SETTLE. If col_idx == COLS-1, wrap to IDLE instead.
  - rs one-hot: latch row_idx and pattern, go to DEBOUNCE with counter=1.
  - rs multi-hot: go to GHOST.
- DEBOUNCE: column held.
  - rs == latched pattern: counter++. When it reaches DEBOUNCE_CYCLES, push code and go to PRESSED.
  - Any mismatch: go to IDLE, no push.
- PRESSED: key_held=1, column held. When rs == 0, go to RELEASE with counter=1.
- RELEASE: rs == 0 for DEBOUNCE_CYCLES consecutive cycles, then IDLE. Any nonzero rs returns to PRESSED with no new push (bounce on release never yields a second code).
- GHOST: col_drive all-ones, no push. Stay until rs == 0 for DEBOUNCE_CYCLES consecutive cycles, then IDLE.
- Push latency: code enters the FIFO on the clock edge leaving DEBOUNCE. key_valid rises the next cycle if the FIFO was empty.
- FIFO handshake: pop when key_valid & key_ready. key_code is the head entry, or 0 when empty.
- FIFO full:
  - push with no pop: code dropped, overflow set.
  - push and pop in the same cycle: both occur, no overflow.
  - overflow_clr and an overflow event in the same cycle: overflow stays 1.
- Empty pop attempts are ignored.
- Reset mid-operation flushes the FIFO and discards any in-progress debounce.
- Pointer width is $clog2(FIFO_DEPTH)+1; pointers wrap naturally.

Decomposition:
- Shared package keypad_pkg: FSM state enum, function for code width, default parameter constants.
- One sub-module, keypad_key_fifo: parametrised sync FIFO (push, pop, full, empty, head) with active-low async reset.
- Synchroniser and FSM stay inline.

Test Plan:
- ROWS=COLS=4, DEBOUNCE_CYCLES=4: press row2/col1, held 50 cycles, ready=1 -> exactly one key_valid beat with key_code=9; key_held=1 until release debounced.
- Press row0/col0 for only 2 cycles after SAMPLE -> no code, FSM back in IDLE, key_valid stays 0.
- Rows 0 and 3 asserted simultaneously on col 2 -> GHOST, no code; release -> IDLE; then row1/col3 -> code 7.
- key_ready=0, press codes 1,2,3,4,5 in turn -> FIFO holds 1,2,3,4, overflow=1; raise ready -> codes drain in order 1,2,3,4; overflow_clr -> overflow=0.
- FIFO full (4 entries) with ready=1 on the same cycle a 5th key is accepted -> no overflow; drain order intact.
- Assert reset low during DEBOUNCE with 2 codes queued -> all outputs at reset values immediately (async); after release of reset, no stale code emitted.
